// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU.
// One quotient bit per cycle on operand magnitudes, with sign fix-up when the result is written.
module div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dmag;
    logic [WIDTH-1:0]   r_dvd_orig;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div_zero;

    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dsr_mag;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    // Magnitudes are taken as unsigned, so |0x8000_0000| stays 0x8000_0000.
    assign w_dvd_mag = (sign && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
    assign w_dsr_mag = (sign && divisor[WIDTH-1]) ? (~divisor + 1'b1) : divisor;

    // rem < divisor always holds, so the low WIDTH bits of the difference are exact when w_ge.
    assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_dmag});
    assign w_diff    = w_rem_sh[WIDTH-1:0] - r_dmag;
    assign w_rem_nxt = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

    assign w_q_fix = r_div_zero ? {WIDTH{1'b1}} :
                     (r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt);
    assign w_r_fix = r_div_zero ? r_dvd_orig :
                     (r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dmag     <= '0;
            r_dvd_orig <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            q          <= '0;
            r          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_state    <= StBusy;
                        r_cnt      <= '0;
                        r_rem      <= '0;
                        r_quo      <= w_dvd_mag;
                        r_dmag     <= w_dsr_mag;
                        r_dvd_orig <= dividend;
                        r_neg_q    <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg_r    <= sign & dividend[WIDTH-1];
                        r_div_zero <= (divisor == '0);
                        busy       <= 1'b1;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StBusy: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        q       <= w_q_fix;
                        r       <= w_r_fix;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
